morse_decoder: RTL and testbench
================================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: tick  input  1  one-cycle strobe marking one Morse time unit; all durations counted in ticks.
REQ-004 SHALL have port: key_in  input  1  key level, already synchronized (1 = tone on).
REQ-005 SHALL have port: char_code  output  8  decoded symbols, left-aligned: bit 7 = first symbol, dash = 1, dot = 0, unused bits 0.
REQ-006 SHALL have port: char_len  output  4  symbol count 0..8; 0 = word space.
REQ-007 SHALL have port: char_vald  output  1  one-cycle pulse; char_code/char_len valid and held until next pulse.
REQ-008 SHALL have port: err  output  1  one-cycle pulse on overflow (more than 8 symbols).

Function
REQ-009 SHALL implement states IDLE, MARK, GAP, WAIT_WORD.
REQ-010 IDLE: key_in=1 -> MARK, mark count cleared; key_in=0 -> stay.
REQ-011 MARK: count ticks while key_in=1, 4-bit saturating at 15; on key_in=0 classify: count <= 2 -> dot, count >= 3 -> dash (0 counts as dot); append symbol; go GAP with gap count cleared.
REQ-012 GAP: count ticks while key_in=0, saturating; key_in=1 with count < 3 -> MARK (same character).
REQ-013 GAP: count reaching 3 -> emit character (char_vald pulse, code/len updated same edge), clear symbol buffer, go WAIT_WORD.
REQ-014 WAIT_WORD: key_in=1 -> MARK (new character); gap count reaching 7 (total from last mark) -> word-space handling per REQ-022/023, then IDLE.
REQ-015 Symbol append with 8 symbols already held SHALL pulse err, discard buffer, suppress char_vald for that character; decoding resumes at next letter gap (GAP/WAIT_WORD flow continues with empty buffer, no emission).
REQ-016 Latency: char_vald asserts on the clk edge where the third gap tick is sampled; no additional pipeline.
REQ-017 tick and key_in edge in same cycle: key level change takes precedence; the tick is not counted in the old state.
REQ-018 tick asserted for consecutive cycles SHALL count each cycle.

Reset
REQ-019 On reset=1 at clk edge: state IDLE, counters 0, symbol buffer empty, char_code 8'h00, char_len 4'h0, char_vald 0, err 0.
REQ-020 Reset mid-character SHALL discard partial character with no char_vald or err pulse.
REQ-021 Reset SHALL dominate tick and key_in in the same cycle.

Configuration
REQ-022 With MORSE_DEC_WORDSPACE_EN defined: reaching gap count 7 in WAIT_WORD SHALL emit one space (char_vald pulse, char_code 8'h00, char_len 0), then IDLE; only one space per gap regardless of gap length.
REQ-023 Without MORSE_DEC_WORDSPACE_EN: no space emitted; WAIT_WORD goes to IDLE silently at count 7.

Structure
REQ-024 Shared package morse_pkg SHALL hold: state encoding, DOT_MAX=2, LETTER_GAP=3, WORD_GAP=7, MAX_SYMS=8, SYM_DOT=0, SYM_DASH=1; the encoder side uses the same constants.
REQ-025 One sub-module unit_counter (4-bit, tick-enabled, synchronous clear, saturating at 15) SHALL be instantiated for mark and gap timing.

Verification
REQ-026 Key "A" (1 on, 1 off, 3 on, 3 off) -> one char_vald, char_code 8'b01000000, char_len 1... corrected: char_len 2.
REQ-027 Eight dashes then 3-unit gap -> char_code 8'hFF, char_len 8, no err; nine dashes -> err pulse, no char_vald.
REQ-028 "E" then 7-unit silence -> char_vald (8'h00, len 1), then with MORSE_DEC_WORDSPACE_EN a second char_vald (8'h00, len 0); without it only the first.
REQ-029 Reset asserted after two dots of a character -> all outputs 0, no pulses; next "T" (3 on, 3 off) -> 8'b10000000, len 1.
REQ-030 Mark of 2 units -> dot; mark of 15+ units (saturated) -> dash; 2-unit gap between marks keeps one character.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse constants and FSM state encoding.
// Used by the decoder here and by the matching encoder, so timing thresholds
// and symbol polarity stay identical on both sides of the link.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    WAIT_WORD
  } state_t;

  localparam logic [3:0] DOT_MAX    = 4'd2;
  localparam logic [3:0] LETTER_GAP = 4'd3;
  localparam logic [3:0] WORD_GAP   = 4'd7;
  localparam logic [3:0] MAX_SYMS   = 4'd8;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // A mark of DOT_MAX units or fewer (including zero) is a dot.
  function automatic logic classify_mark(input logic [3:0] cnt);
    return (cnt > DOT_MAX) ? SYM_DASH : SYM_DOT;
  endfunction

endpackage

// File: rtl/morse_decoder_unit_counter.sv
// unit_counter: 4-bit tick counter with synchronous clear, saturating at 15.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   i_clr   - synchronous clear (wins over i_tick)
//   i_tick  - count enable, one increment per cycle it is high
//   o_cnt   - current count
module unit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_tick,
  output logic [3:0] o_cnt
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_tick && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: turns a keyed tone level into Morse characters.
// Mark lengths are measured in ticks and classified as dot/dash; a 3-unit
// silence closes a character, a 7-unit silence closes a word.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   tick       - one-cycle strobe per Morse time unit
//   key_in     - synchronized key level (1 = tone on)
//   char_code  - symbols left-aligned, bit 7 first, dash = 1
//   char_len   - symbol count 0..8 (0 = word space)
//   char_vald  - one-cycle pulse, code/len held until the next pulse
//   err        - one-cycle pulse when a character exceeds 8 symbols
// Optional feature: define MORSE_DEC_WORDSPACE_EN to emit a word-space
// character (code 0, len 0) once per word gap.
module morse_decoder
  import morse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_in,
  output logic [7:0] char_code,
  output logic [3:0] char_len,
  output logic       char_vald,
  output logic       err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_mark_clr;
  logic       w_gap_clr;
  logic       w_append;
  logic       w_letter_gap;
  logic [3:0] w_mark_cnt;
  logic [3:0] w_gap_cnt;
  logic       w_mark_tick;
  logic       w_gap_tick;
  logic       w_sym;

  logic [7:0] r_sym;
  logic [3:0] r_len;
  logic       r_drop;
  logic [7:0] r_char_code;
  logic [3:0] r_char_len;
  logic       r_char_vald;
  logic       r_err;

  // Counters only advance while the key stays at the level their state
  // measures, so a tick coinciding with a key edge is never counted in
  // the state being left.
  assign w_mark_tick = tick && (r_state == MARK) && key_in;
  assign w_gap_tick  = tick && ((r_state == GAP) || (r_state == WAIT_WORD)) && !key_in;

  unit_counter u_mark_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_mark_clr),
    .i_tick (w_mark_tick),
    .o_cnt  (w_mark_cnt)
  );

  unit_counter u_gap_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_gap_clr),
    .i_tick (w_gap_tick),
    .o_cnt  (w_gap_cnt)
  );

  assign w_sym = classify_mark(w_mark_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Gap thresholds fire on the edge that samples the tick bringing the
  // count to the threshold, hence the compare against threshold - 1.
  always_comb begin
    w_state_nxt  = r_state;
    w_mark_clr   = 1'b0;
    w_gap_clr    = 1'b0;
    w_append     = 1'b0;
    w_letter_gap = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_in) begin
          w_state_nxt = MARK;
          w_mark_clr  = 1'b1;
        end
      end
      MARK: begin
        if (!key_in) begin
          w_append    = 1'b1;
          w_gap_clr   = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (key_in) begin
          w_state_nxt = MARK;
          w_mark_clr  = 1'b1;
        end else if (tick && (w_gap_cnt == LETTER_GAP - 4'd1)) begin
          w_letter_gap = 1'b1;
          w_state_nxt  = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (key_in) begin
          w_state_nxt = MARK;
          w_mark_clr  = 1'b1;
        end else if (tick && (w_gap_cnt == WORD_GAP - 4'd1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Symbol buffer and output registers. After an overflow r_drop swallows
  // the rest of the character so it produces neither a second err nor a
  // char_vald; the next letter gap re-arms decoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym       <= 8'h00;
      r_len       <= 4'd0;
      r_drop      <= 1'b0;
      r_char_code <= 8'h00;
      r_char_len  <= 4'd0;
      r_char_vald <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_char_vald <= 1'b0;
      r_err       <= 1'b0;
      if (w_append && !r_drop) begin
        if (r_len == MAX_SYMS) begin
          r_err  <= 1'b1;
          r_sym  <= 8'h00;
          r_len  <= 4'd0;
          r_drop <= 1'b1;
        end else begin
          r_sym[3'd7 - r_len[2:0]] <= w_sym;
          r_len                    <= r_len + 4'd1;
        end
      end
      if (w_letter_gap) begin
        if (!r_drop) begin
          r_char_vald <= 1'b1;
          r_char_code <= r_sym;
          r_char_len  <= r_len;
        end
        r_sym  <= 8'h00;
        r_len  <= 4'd0;
        r_drop <= 1'b0;
      end
`ifdef MORSE_DEC_WORDSPACE_EN
      if ((r_state == WAIT_WORD) && (w_state_nxt == IDLE)) begin
        r_char_vald <= 1'b1;
        r_char_code <= 8'h00;
        r_char_len  <= 4'd0;
      end
`else
`endif
    end
  end

  assign char_code = r_char_code;
  assign char_len  = r_char_len;
  assign char_vald = r_char_vald;
  assign err       = r_err;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed testbench for morse_decoder: a table of keyed characters plus
// hand-written sequences for latency, precedence, word gap and reset.
// One Morse unit = 4 clocks: key level set, then a tick on the next cycle.
module tb_morse_decoder;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       key_in;
  logic [7:0] char_code;
  logic [3:0] char_len;
  logic       char_vald;
  logic       err;

  int total = 0;
  int bad   = 0;
  int n_vald = 0;
  int n_err  = 0;
  int base_v;
  int base_e;
  int exp_sp;

  morse_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .key_in    (key_in),
    .char_code (char_code),
    .char_len  (char_len),
    .char_vald (char_vald),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (char_vald) n_vald <= n_vald + 1;
    if (err)       n_err  <= n_err + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1);
  end

  typedef struct {
    string      name;
    int         nsym;
    logic [8:0] dash;
    int         dot_u;
    int         dash_u;
    int         gap_u;
    int         exp_vald;
    int         exp_err;
    logic [7:0] exp_code;
    logic [3:0] exp_len;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic units(input logic lvl, input int n);
    for (int u = 0; u < n; u++) begin
      key_in = lvl;
      tick   = 1'b0;
      @(posedge clk); #1;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{"A",      2, 9'b000000010, 1, 3,  1, 1, 0, 8'b01000000, 4'd2};
    tbl[1] = '{"T",      1, 9'b000000001, 1, 3,  1, 1, 0, 8'b10000000, 4'd1};
    tbl[2] = '{"8dash",  8, 9'b011111111, 1, 3,  1, 1, 0, 8'hFF,       4'd8};
    tbl[3] = '{"9dash",  9, 9'b111111111, 1, 3,  1, 0, 1, 8'h00,       4'd0};
    tbl[4] = '{"dot2sat",2, 9'b000000010, 2, 17, 2, 1, 0, 8'b01000000, 4'd2};
    tbl[5] = '{"K",      3, 9'b000000101, 1, 3,  1, 1, 0, 8'b10100000, 4'd3};

    reset  = 1'b1;
    tick   = 1'b0;
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", char_code, 0);
    chk("rst_len",  char_len,  0);
    chk("rst_vald", char_vald, 0);
    chk("rst_err",  err,       0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      base_v = n_vald;
      base_e = n_err;
      for (int i = 0; i < tbl[v].nsym; i++) begin
        units(1'b1, tbl[v].dash[i] ? tbl[v].dash_u : tbl[v].dot_u);
        units(1'b0, (i == tbl[v].nsym - 1) ? 3 : tbl[v].gap_u);
      end
      chk({tbl[v].name, "_vald"}, n_vald - base_v, tbl[v].exp_vald);
      chk({tbl[v].name, "_err"},  n_err - base_e,  tbl[v].exp_err);
      if (tbl[v].exp_vald == 1) begin
        chk({tbl[v].name, "_code"}, char_code, tbl[v].exp_code);
        chk({tbl[v].name, "_len"},  char_len,  tbl[v].exp_len);
      end
    end

    // "E": char_vald on the edge of the third gap tick, one cycle wide
    base_v = n_vald;
    units(1'b1, 1);
    key_in = 1'b0;
    tick   = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      chk($sformatf("lat_vald_t%0d", k), char_vald, (k == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("lat_pulse_end", char_vald, 0);
    chk("E_code", char_code, 8'h00);
    chk("E_len",  char_len,  1);

    // Word gap: 4 more silent units completes the 7-unit gap
`ifdef MORSE_DEC_WORDSPACE_EN
    exp_sp = 1;
`else
    exp_sp = 0;
`endif
    units(1'b0, 4);
    chk("wordgap_vald", n_vald - base_v, 1 + exp_sp);
    chk("wordgap_len",  char_len, (exp_sp == 1) ? 0 : 1);
    units(1'b0, 10);
    chk("wordgap_once", n_vald - base_v, 1 + exp_sp);

    // Key edge and tick together in GAP with count 2: key wins, no emission
    base_v = n_vald;
    units(1'b1, 1);
    key_in = 1'b0;
    tick   = 1'b0;
    @(posedge clk); #1;
    repeat (2) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
    end
    key_in = 1'b1;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    units(1'b1, 3);
    units(1'b0, 3);
    chk("prec_vald", n_vald - base_v, 1);
    chk("prec_code", char_code, 8'b01000000);
    chk("prec_len",  char_len,  2);

    // Consecutive-cycle ticks: 3 back-to-back ticks make a dash
    base_v = n_vald;
    key_in = 1'b1;
    tick   = 1'b0;
    @(posedge clk); #1;
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b0;
    units(1'b0, 3);
    chk("burst_vald", n_vald - base_v, 1);
    chk("burst_code", char_code, 8'b10000000);
    chk("burst_len",  char_len,  1);

    // Reset after two dots, with tick and key high in the reset cycle
    units(1'b1, 1);
    units(1'b0, 1);
    units(1'b1, 1);
    units(1'b0, 1);
    base_v = n_vald;
    base_e = n_err;
    reset  = 1'b1;
    key_in = 1'b1;
    tick   = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    key_in = 1'b0;
    tick   = 1'b0;
    chk("midrst_code", char_code, 0);
    chk("midrst_len",  char_len,  0);
    chk("midrst_vald", char_vald, 0);
    units(1'b0, 8);
    chk("midrst_nopulse", n_vald - base_v, 0);
    chk("midrst_noerr",   n_err - base_e,  0);
    units(1'b1, 3);
    units(1'b0, 3);
    chk("postrst_vald", n_vald - base_v, 1);
    chk("postrst_code", char_code, 8'b10000000);
    chk("postrst_len",  char_len,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
